// File: rtl/riscv_if_fetch_pkg.sv
// Shared constants, FSM encoding and PC helper for the instruction-fetch stage.
package riscv_if_fetch_pkg;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'h0000_0004;

   localparam int STALL_IF = 0;
   localparam int STALL_ID = 1;

   typedef enum logic [0:0] {
      FETCH_IDLE = 1'b0,
      FETCH_WAIT = 1'b1
   } fetch_state_e;

   // Sequential fetch address; wraps silently at 2^32.
   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/riscv_if_fetch_skid.sv
// One-entry {pc, inst} holding buffer used when ID refuses a returned instruction.
module riscv_if_fetch_skid
   import riscv_if_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_unload,
   input  logic        i_clear,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_inst,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_inst;

   // Clear beats load so a branch always flushes; load beats unload so a swap keeps the entry full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= ZERO_WORD;
         r_inst  <= NOP_INST;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_inst  <= i_inst;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_inst  = r_inst;

endmodule

// File: rtl/riscv_if_fetch.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, one-entry skid and the IF/ID pipeline register.
module riscv_if_fetch
   import riscv_if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  stall_i,
   input  logic        br_i,
   input  logic [31:0] br_target_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_rdata_i,
   output logic        inst_busy_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o
);

   fetch_state_e r_state, w_state_n;
   logic [31:0]  r_pc, w_pc_n;
   logic [31:0]  r_addr, w_addr_n;
   logic         r_req, w_req_n;
   logic         r_discard, w_discard_n;
   logic [31:0]  r_id_pc, w_id_pc_n;
   logic [31:0]  r_id_inst, w_id_inst_n;
   logic         r_id_valid, w_id_valid_n;

   logic         w_stall_if, w_stall_id;
   logic         w_ack, w_ack_keep;
   logic         w_skid_valid, w_skid_load, w_skid_unload, w_skid_clear, w_skid_full_n;
   logic [31:0]  w_skid_pc, w_skid_inst;
   logic         w_unused_stall;

   assign w_stall_if     = stall_i[STALL_IF];
   assign w_stall_id     = stall_i[STALL_ID];
   assign w_unused_stall = ^stall_i[4:2];
   assign w_ack          = (r_state == FETCH_WAIT) && inst_ack_i;
   assign w_ack_keep     = w_ack && !r_discard;

   riscv_if_fetch_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_clear  (w_skid_clear),
      .i_pc     (r_addr),
      .i_inst   (inst_rdata_i),
      .o_valid  (w_skid_valid),
      .o_pc     (w_skid_pc),
      .o_inst   (w_skid_inst)
   );

   // Next-state, fetch-request and IF/ID update; a branch overrides every stall.
   always_comb begin
      w_state_n     = r_state;
      w_pc_n        = r_pc;
      w_addr_n      = r_addr;
      w_req_n       = r_req;
      w_discard_n   = r_discard;
      w_id_pc_n     = r_id_pc;
      w_id_inst_n   = r_id_inst;
      w_id_valid_n  = r_id_valid;
      w_skid_load   = 1'b0;
      w_skid_unload = 1'b0;
      w_skid_clear  = 1'b0;
      w_skid_full_n = w_skid_valid;

      if (br_i) begin
         w_pc_n        = br_target_i;
         w_skid_clear  = 1'b1;
         w_skid_full_n = 1'b0;
         w_id_pc_n     = ZERO_WORD;
         w_id_inst_n   = NOP_INST;
         w_id_valid_n  = 1'b0;
         if (r_state == FETCH_WAIT) begin
            if (w_ack) begin
               w_state_n   = FETCH_IDLE;
               w_req_n     = 1'b0;
               w_discard_n = 1'b0;
            end else begin
               // The outstanding fetch cannot be cancelled on the bus, so its data is dropped later.
               w_discard_n = 1'b1;
            end
         end else begin
            w_state_n = FETCH_IDLE;
         end
      end else begin
         if (!w_stall_id) begin
            if (w_skid_valid) begin
               w_id_pc_n     = w_skid_pc;
               w_id_inst_n   = w_skid_inst;
               w_id_valid_n  = 1'b1;
               w_skid_unload = 1'b1;
            end else if (w_ack_keep) begin
               w_id_pc_n    = r_addr;
               w_id_inst_n  = inst_rdata_i;
               w_id_valid_n = 1'b1;
            end else begin
               w_id_pc_n    = ZERO_WORD;
               w_id_inst_n  = NOP_INST;
               w_id_valid_n = 1'b0;
            end
         end else begin
            w_id_valid_n = r_id_valid;
         end

         w_skid_load   = w_ack_keep && (w_stall_id || w_skid_valid);
         w_skid_full_n = w_skid_load || (w_skid_valid && !w_skid_unload);

         case (r_state)
            FETCH_IDLE: begin
               if (!w_stall_if && !w_skid_valid) begin
                  w_state_n = FETCH_WAIT;
                  w_req_n   = 1'b1;
                  w_addr_n  = r_pc;
               end else begin
                  w_state_n = FETCH_IDLE;
               end
            end
            FETCH_WAIT: begin
               if (w_ack && r_discard) begin
                  w_state_n   = FETCH_IDLE;
                  w_req_n     = 1'b0;
                  w_discard_n = 1'b0;
               end else if (w_ack) begin
                  w_pc_n = pc_incr(r_pc);
                  if (!w_stall_if && !w_skid_full_n) begin
                     w_addr_n = pc_incr(r_pc);
                  end else begin
                     w_state_n = FETCH_IDLE;
                     w_req_n   = 1'b0;
                  end
               end else begin
                  w_state_n = FETCH_WAIT;
               end
            end
            default: begin
               w_state_n = FETCH_IDLE;
               w_req_n   = 1'b0;
            end
         endcase
      end
   end

   // FSM state and fetch-side registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FETCH_IDLE;
         r_pc      <= RESET_PC;
         r_addr    <= ZERO_WORD;
         r_req     <= 1'b0;
         r_discard <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_pc      <= w_pc_n;
         r_addr    <= w_addr_n;
         r_req     <= w_req_n;
         r_discard <= w_discard_n;
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_pc    <= ZERO_WORD;
         r_id_inst  <= NOP_INST;
         r_id_valid <= 1'b0;
      end else begin
         r_id_pc    <= w_id_pc_n;
         r_id_inst  <= w_id_inst_n;
         r_id_valid <= w_id_valid_n;
      end
   end

   assign inst_req_o  = r_req;
   assign inst_addr_o = r_addr;
   assign inst_busy_o = (r_state == FETCH_WAIT) && !inst_ack_i;
   assign id_pc_o     = r_id_pc;
   assign id_inst_o   = r_id_inst;
   assign id_valid_o  = r_id_valid;

endmodule

// File: tb/tb_riscv_if_fetch.sv
// Directed self-checking bench for riscv_if_fetch with RESET_PC = 0x100.
module tb_riscv_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  stall_i = 5'b00000;
   logic        br_i = 1'b0;
   logic [31:0] br_target_i = 32'h0;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_ack_i = 1'b0;
   logic [31:0] inst_rdata_i = 32'h0;
   logic        inst_busy_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   riscv_if_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .br_i         (br_i),
      .br_target_i  (br_target_i),
      .inst_req_o   (inst_req_o),
      .inst_addr_o  (inst_addr_o),
      .inst_ack_i   (inst_ack_i),
      .inst_rdata_i (inst_rdata_i),
      .inst_busy_o  (inst_busy_o),
      .id_pc_o      (id_pc_o),
      .id_inst_o    (id_inst_o),
      .id_valid_o   (id_valid_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [4:0] stall_after);
      rst = 1'b1; br_i = 1'b0; inst_ack_i = 1'b0; stall_i = 5'b00000;
      cyc(); cyc();
      stall_i = stall_after;
      rst = 1'b0;
   endtask

   // From a fresh reset held in IDLE by stall_i[0], redirect the PC and let the first fetch issue.
   task automatic start_at(input logic [31:0] target);
      do_reset(5'b00001);
      br_i = 1'b1; br_target_i = target;
      cyc();
      br_i = 1'b0; stall_i = 5'b00000;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; inst_ack_i = 1'b1;
      #2;
      checks++; if (inst_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", inst_busy_o); end
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", inst_req_o); end
      checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
      checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h want 0", id_pc_o); end
      checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL rst_id_inst: got %h want %h", id_inst_o, NOP); end
      checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b want 0", id_valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr_exp [4];
      addr_exp[0] = 32'h100; addr_exp[1] = 32'h104; addr_exp[2] = 32'h108; addr_exp[3] = 32'h10C;
      do_reset(5'b00000);
      cyc();
      checks++; if (inst_req_o !== 1'b1) begin errors++; $display("FAIL b2b_first_req: got %b want 1", inst_req_o); end
      checks++; if (inst_busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", inst_busy_o); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (inst_addr_o !== addr_exp[i]) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, inst_addr_o, addr_exp[i]); end
         inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0000 | addr_exp[i];
         cyc();
         checks++; if (id_pc_o !== addr_exp[i]) begin errors++; $display("FAIL b2b_id_pc%0d: got %h want %h", i, id_pc_o, addr_exp[i]); end
         checks++; if (id_inst_o !== (32'hABCD_0000 | addr_exp[i])) begin errors++; $display("FAIL b2b_id_inst%0d: got %h", i, id_inst_o); end
         checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", i, id_valid_o); end
         checks++; if (inst_req_o !== 1'b1) begin errors++; $display("FAIL b2b_req%0d: got %b want 1", i, inst_req_o); end
      end
      checks++; if (inst_addr_o !== addr_exp[3]) begin errors++; $display("FAIL b2b_addr3: got %h want %h", inst_addr_o, addr_exp[3]); end
      inst_ack_i = 1'b0;
   endtask

   task automatic test_wait_states();
      do_reset(5'b00000);
      cyc();
      for (int i = 0; i < 3; i++) begin
         checks++; if (inst_busy_o !== 1'b1) begin errors++; $display("FAIL ws_busy%0d: got %b want 1", i, inst_busy_o); end
         checks++; if (inst_addr_o !== 32'h100 || inst_req_o !== 1'b1) begin errors++; $display("FAIL ws_addr%0d: got %h req %b want 100 req 1", i, inst_addr_o, inst_req_o); end
         checks++; if (id_valid_o !== 1'b0 || id_inst_o !== NOP) begin errors++; $display("FAIL ws_bubble%0d: got v=%b inst=%h want v=0 NOP", i, id_valid_o, id_inst_o); end
         cyc();
      end
      inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0100;
      #1;
      checks++; if (inst_busy_o !== 1'b0) begin errors++; $display("FAIL ws_busy_ack: got %b want 0", inst_busy_o); end
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (id_pc_o !== 32'h100 || id_valid_o !== 1'b1) begin errors++; $display("FAIL ws_id: got %h v=%b want 100 v=1", id_pc_o, id_valid_o); end
      checks++; if (inst_addr_o !== 32'h104) begin errors++; $display("FAIL ws_next_addr: got %h want 104", inst_addr_o); end
   endtask

   task automatic test_id_hold();
      start_at(32'h200);
      checks++; if (inst_addr_o !== 32'h200 || inst_req_o !== 1'b1) begin errors++; $display("FAIL hold_start: got %h req %b want 200 req 1", inst_addr_o, inst_req_o); end
      inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0200;
      cyc();
      checks++; if (inst_addr_o !== 32'h204 || id_pc_o !== 32'h200) begin errors++; $display("FAIL hold_pre: got addr %h id %h want 204 200", inst_addr_o, id_pc_o); end
      inst_rdata_i = 32'hABCD_0204; stall_i = 5'b00011;
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL hold_no_req: got %b want 0", inst_req_o); end
      checks++; if (id_pc_o !== 32'h200 || id_valid_o !== 1'b1) begin errors++; $display("FAIL hold_id_held: got %h v=%b want 200 v=1", id_pc_o, id_valid_o); end
      cyc();
      checks++; if (inst_req_o !== 1'b0 || id_pc_o !== 32'h200) begin errors++; $display("FAIL hold_still: got req %b id %h want 0 200", inst_req_o, id_pc_o); end
      stall_i = 5'b00000;
      cyc();
      checks++; if (id_pc_o !== 32'h204 || id_inst_o !== 32'hABCD_0204 || id_valid_o !== 1'b1) begin errors++; $display("FAIL hold_release: got %h %h v=%b want 204 abcd0204 v=1", id_pc_o, id_inst_o, id_valid_o); end
      cyc();
      checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h208) begin errors++; $display("FAIL hold_next_req: got req %b addr %h want 1 208", inst_req_o, inst_addr_o); end
      checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL hold_bubble: got %b want 0", id_valid_o); end
   endtask

   task automatic test_branch_mid_fetch();
      start_at(32'h300);
      br_i = 1'b1; br_target_i = 32'h400;
      cyc();
      br_i = 1'b0;
      checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h300) begin errors++; $display("FAIL brm_pending: got req %b addr %h want 1 300", inst_req_o, inst_addr_o); end
      inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0300;
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (id_valid_o !== 1'b0 || id_inst_o !== NOP) begin errors++; $display("FAIL brm_dropped: got v=%b inst %h want v=0 NOP", id_valid_o, id_inst_o); end
      checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL brm_idle: got req %b want 0", inst_req_o); end
      cyc();
      checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h400) begin errors++; $display("FAIL brm_target: got req %b addr %h want 1 400", inst_req_o, inst_addr_o); end
      checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL brm_wait_bubble: got %b want 0", id_valid_o); end
      inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0400;
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (id_pc_o !== 32'h400 || id_valid_o !== 1'b1) begin errors++; $display("FAIL brm_arrive: got %h v=%b want 400 v=1", id_pc_o, id_valid_o); end
   endtask

   task automatic test_branch_twice();
      start_at(32'h300);
      br_i = 1'b1; br_target_i = 32'h400;
      cyc();
      br_target_i = 32'h500;
      cyc();
      br_i = 1'b0; inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0300;
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (id_valid_o !== 1'b0 || inst_req_o !== 1'b0) begin errors++; $display("FAIL br2_drop: got v=%b req %b want 0 0", id_valid_o, inst_req_o); end
      cyc();
      checks++; if (inst_addr_o !== 32'h500 || inst_req_o !== 1'b1) begin errors++; $display("FAIL br2_target: got %h req %b want 500 1", inst_addr_o, inst_req_o); end
   endtask

   task automatic test_branch_coincident();
      start_at(32'h500);
      inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0500; stall_i = 5'b00011;
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL brc_skid_req: got %b want 0", inst_req_o); end
      br_i = 1'b1; br_target_i = 32'h600;
      cyc();
      br_i = 1'b0; stall_i = 5'b00000;
      checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL brc_skid_bubble: got %b want 0", id_valid_o); end
      cyc();
      checks++; if (id_valid_o !== 1'b0 || id_pc_o === 32'h500) begin errors++; $display("FAIL brc_skid_flushed: got v=%b pc %h want v=0", id_valid_o, id_pc_o); end
      checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h600) begin errors++; $display("FAIL brc_skid_target: got req %b addr %h want 1 600", inst_req_o, inst_addr_o); end
      inst_ack_i = 1'b1; inst_rdata_i = 32'hABCD_0600; br_i = 1'b1; br_target_i = 32'h700;
      cyc();
      inst_ack_i = 1'b0; br_i = 1'b0;
      checks++; if (inst_req_o !== 1'b0 || id_valid_o !== 1'b0) begin errors++; $display("FAIL brc_ack_drop: got req %b v=%b want 0 0", inst_req_o, id_valid_o); end
      cyc();
      checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h700) begin errors++; $display("FAIL brc_ack_target: got req %b addr %h want 1 700", inst_req_o, inst_addr_o); end
   endtask

   task automatic test_async_reset();
      do_reset(5'b00000);
      cyc();
      checks++; if (inst_req_o !== 1'b1) begin errors++; $display("FAIL ar_req_before: got %b want 1", inst_req_o); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (inst_req_o !== 1'b0 || inst_busy_o !== 1'b0) begin errors++; $display("FAIL ar_async_drop: got req %b busy %b want 0 0", inst_req_o, inst_busy_o); end
      cyc(); cyc();
      rst = 1'b0; inst_ack_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
      cyc();
      inst_ack_i = 1'b0;
      checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ar_late_ack: got v=%b want 0", id_valid_o); end
      checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h100) begin errors++; $display("FAIL ar_restart: got req %b addr %h want 1 100", inst_req_o, inst_addr_o); end
      #1;
      checks++; if (inst_busy_o !== 1'b1) begin errors++; $display("FAIL ar_busy: got %b want 1", inst_busy_o); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_wait_states();
      test_id_hold();
      test_branch_mid_fetch();
      test_branch_twice();
      test_branch_coincident();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
